// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback source encoding used by the
// writeback port arbiter and its clients.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int N_WB_SRC   = 3;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// pointer moves past the granted requester whenever the grant is taken.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = N_WB_SRC,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] gnt_idx;
  logic             found;
  int               scan;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    scan    = 0;
    for (int k = 0; k < N; k++) begin
      scan = int'(ptr) + k;
      if (scan >= N) scan = scan - N;
      if (!found && req[scan]) begin
        gnt[scan] = 1'b1;
        gnt_idx   = PTR_W'(scan);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the writeback sources onto the single register-file write port
// and tracks which registers still have a write in flight.
module wb_port_arbiter #(
  parameter int N_SRC    = regfile_pkg::N_WB_SRC,
  parameter int ADDR_W   = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W   = regfile_pkg::XLEN,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  input  logic [N_SRC*ADDR_W-1:0]    src_addr,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_rd,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       write_en,
  output logic [NUM_REGS-1:0]        pending
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]    gnt;
  logic [PTR_W-1:0]    ptr;
  logic                vld_p0;
  logic [ADDR_W-1:0]   sel_addr_p0;
  logic [DATA_W-1:0]   sel_data_p0;
  logic                vld_p1;
  logic [ADDR_W-1:0]   wr_addr_p1;
  logic [DATA_W-1:0]   wr_data_p1;
  logic [NUM_REGS-1:0] pending_p2;
  logic [NUM_REGS-1:0] pending_nxt;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (src_valid),
    .advance (vld_p0),
    .gnt     (gnt),
    .ptr     (ptr)
  );

  // Stage p0: grant and source select; reset masks any acceptance.
  assign src_ready = reset ? '0 : gnt;
  assign vld_p0    = |(src_valid & src_ready);

  always_comb begin
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_ready[i]) begin
        sel_addr_p0 = src_addr[i*ADDR_W +: ADDR_W];
        sel_data_p0 = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: registered write port; x0 targets are accepted but never strobed.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0 && (sel_addr_p0 != '0);
      if (vld_p0) begin
        wr_addr_p1 <= sel_addr_p0;
        wr_data_p1 <= sel_data_p0;
      end
    end
  end

  assign write_en = vld_p1;
  assign wr_addr  = wr_addr_p1;
  assign wr_data  = wr_data_p1;

  // Stage p2: scoreboard; a same-cycle issue to the committing register wins.
  always_comb begin
    pending_nxt = pending_p2;
    if (vld_p1) pending_nxt[wr_addr_p1] = 1'b0;
    if (issue_en && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_p2 <= '0;
    else       pending_p2 <= pending_nxt;
  end

  assign pending = pending_p2;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter: grant order, write stage, x0 handling,
// scoreboard set/clear and reset behaviour.
module tb_wb_port_arbiter;
  import regfile_pkg::*;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [NS*AW-1:0]  src_addr;
  logic [NS*DW-1:0]  src_data;
  logic              issue_en;
  logic [AW-1:0]     issue_rd;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              write_en;
  logic [NR-1:0]     pending;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.N_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .write_en  (write_en),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_addr[i*AW +: AW] = a;
    src_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    src_valid = 3'b111;
    src_addr  = '0;
    src_data  = '0;
    issue_en  = 1'b0;
    issue_rd  = '0;
    #1;
    checks++;
    if (src_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready got %b want 000", src_ready);
    end
    tick();
    tick();
    checks++;
    if (src_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready_held got %b want 000", src_ready);
    end
    src_valid = '0;
    reset     = 1'b0;
    #1;
    checks++;
    if (write_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++; $display("FAIL reset_wr got en=%b addr=%0d data=%h want 0/0/0", write_en, wr_addr, wr_data);
    end
    checks++;
    if (pending !== '0) begin
      errors++; $display("FAIL reset_pending got %h want 0", pending);
    end
  endtask

  task automatic test_single_source();
    set_src(WB_MEM, 5'd5, 32'hDEADBEEF);
    src_valid = 3'b010;
    #1;
    checks++;
    if (src_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready got %b want 010", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if (write_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write got en=%b addr=%0d data=%h want 1/5/deadbeef", write_en, wr_addr, wr_data);
    end
    // Pointer now at MDU: with everyone requesting, MDU must win.
    src_valid = 3'b111;
    #1;
    checks++;
    if (src_ready !== 3'b100) begin
      errors++; $display("FAIL single_ptr2 got %b want 100", src_ready);
    end
    src_valid = '0;
    tick();
    checks++;
    if (write_en !== 1'b0 || wr_addr !== 5'd5) begin
      errors++; $display("FAIL single_idle got en=%b addr=%0d want 0/5", write_en, wr_addr);
    end
  endtask

  task automatic test_contention();
    logic [NS-1:0] exp_gnt [6];
    logic [AW-1:0] exp_addr [6];
    exp_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    test_reset();
    set_src(WB_ALU, 5'd1, 32'hA1A1_0001);
    set_src(WB_MEM, 5'd2, 32'hB2B2_0002);
    set_src(WB_MDU, 5'd3, 32'hC3C3_0003);
    src_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (src_ready !== exp_gnt[c]) begin
        errors++; $display("FAIL contention_gnt[%0d] got %b want %b", c, src_ready, exp_gnt[c]);
      end
      tick();
      checks++;
      if (write_en !== 1'b1 || wr_addr !== exp_addr[c]) begin
        errors++; $display("FAIL contention_wr[%0d] got en=%b addr=%0d want 1/%0d", c, write_en, wr_addr, exp_addr[c]);
      end
    end
    checks++;
    if (wr_data !== 32'hC3C3_0003) begin
      errors++; $display("FAIL contention_data got %h want c3c30003", wr_data);
    end
    src_valid = '0;
    tick();
    checks++;
    if (write_en !== 1'b0) begin
      errors++; $display("FAIL contention_idle got en=%b want 0", write_en);
    end
  endtask

  task automatic test_x0();
    set_src(WB_ALU, 5'd0, 32'h0000_1234);
    src_valid = 3'b001;
    #1;
    checks++;
    if (src_ready !== 3'b001) begin
      errors++; $display("FAIL x0_ready got %b want 001", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if (write_en !== 1'b0 || pending !== '0) begin
      errors++; $display("FAIL x0_nowrite got en=%b pending=%h want 0/0", write_en, pending);
    end
    src_valid = 3'b111;
    #1;
    checks++;
    if (src_ready !== 3'b010) begin
      errors++; $display("FAIL x0_ptr_advance got %b want 010", src_ready);
    end
    src_valid = '0;
    tick();
  endtask

  task automatic test_scoreboard();
    test_reset();
    issue_en = 1'b1;
    issue_rd = 5'd7;
    tick();
    issue_en = 1'b0;
    checks++;
    if (pending !== 32'h0000_0080) begin
      errors++; $display("FAIL sb_set got %h want 00000080", pending);
    end
    issue_en = 1'b1;
    issue_rd = 5'd0;
    tick();
    issue_en = 1'b0;
    checks++;
    if (pending !== 32'h0000_0080) begin
      errors++; $display("FAIL sb_x0_issue got %h want 00000080", pending);
    end
    set_src(WB_ALU, 5'd7, 32'h7777_7777);
    src_valid = 3'b001;
    #1;
    checks++;
    if (src_ready !== 3'b001) begin
      errors++; $display("FAIL sb_ready got %b want 001", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if (write_en !== 1'b1 || wr_addr !== 5'd7 || pending !== 32'h0000_0080) begin
      errors++; $display("FAIL sb_commit got en=%b addr=%0d pending=%h want 1/7/00000080", write_en, wr_addr, pending);
    end
    tick();
    checks++;
    if (pending !== '0) begin
      errors++; $display("FAIL sb_clear got %h want 0", pending);
    end
  endtask

  task automatic test_collision();
    issue_en = 1'b1;
    issue_rd = 5'd9;
    tick();
    issue_en = 1'b0;
    // Pointer sits at MEM after the scoreboard test's ALU grant.
    set_src(WB_MEM, 5'd9, 32'h9999_0009);
    src_valid = 3'b010;
    tick();
    src_valid = '0;
    issue_en  = 1'b1;
    issue_rd  = 5'd9;
    checks++;
    if (write_en !== 1'b1 || wr_addr !== 5'd9) begin
      errors++; $display("FAIL coll_commit got en=%b addr=%0d want 1/9", write_en, wr_addr);
    end
    tick();
    issue_en = 1'b0;
    checks++;
    if (pending !== 32'h0000_0200) begin
      errors++; $display("FAIL coll_set_wins got %h want 00000200", pending);
    end
  endtask

  task automatic test_reset_mid();
    // Pointer at MDU after the MEM grant above.
    set_src(WB_MDU, 5'd4, 32'h4444_0004);
    src_valid = 3'b111;
    issue_en  = 1'b1;
    issue_rd  = 5'd12;
    #1;
    checks++;
    if (src_ready !== 3'b100) begin
      errors++; $display("FAIL mid_gnt got %b want 100", src_ready);
    end
    tick();
    issue_en = 1'b0;
    reset    = 1'b1;
    #1;
    checks++;
    if (src_ready !== 3'b000 || write_en !== 1'b1 || wr_addr !== 5'd4) begin
      errors++; $display("FAIL mid_inflight got ready=%b en=%b addr=%0d want 000/1/4", src_ready, write_en, wr_addr);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (write_en !== 1'b0 || pending !== '0) begin
      errors++; $display("FAIL mid_dropped got en=%b pending=%h want 0/0", write_en, pending);
    end
    checks++;
    if (src_ready !== 3'b001) begin
      errors++; $display("FAIL mid_ptr_reset got %b want 001", src_ready);
    end
    src_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_contention();
    test_x0();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
